// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and lane helpers for the load/store bus master
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size is funct3[1:0]; 2'b11 has no RV32I meaning.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_t;

    function automatic logic decode_err(input logic we, input logic [1:0] a, input logic [2:0] f3);
        case (lsu_size_t'(f3[1:0]))
            SZ_X:    decode_err = 1'b1;
            SZ_H:    decode_err = (we & f3[2]) | a[0];
            SZ_W:    decode_err = (we & f3[2]) | (a != 2'b00);
            default: decode_err = we & f3[2];
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input lsu_size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    lane_strb = 4'b0001 << a;
            SZ_H:    lane_strb = a[1] ? 4'b1100 : 4'b0011;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input lsu_size_t sz, input logic [31:0] d);
        case (sz)
            SZ_B:    lane_wdata = {4{d[7:0]}};
            SZ_H:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and sign/zero-extends it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  addr,
    input  logic [2:0]  func3,
    output logic [31:0] rdata
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = rword[{addr, 3'b000} +: 8];
        sel_h = addr[1] ? rword[31:16] : rword[15:0];
        case (func3)
            F3_LB:          rdata = {{24{sel_b[7]}}, sel_b};
            F3_LBU:         rdata = {24'd0, sel_b};
            F3_LH:          rdata = {{16{sel_h[15]}}, sel_h};
            F3_LHU:         rdata = {16'd0, sel_h};
            F3_LW:          rdata = rword;
            default:        rdata = rword;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - RV32I load/store initiator driving an APB-style data bus
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        bus_sel,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t    state, state_n;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [2:0]    r_func3;
    logic [31:0]   r_wdata;
    logic [3:0]    r_strb;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [CW-1:0] tcnt;

    logic          dec_err;
    logic          timeout;
    logic [31:0]   load_rdata;

    assign dec_err = decode_err(req_we, req_addr[1:0], req_func3);
    // tcnt holds the number of ACCESS cycles already completed, so TLAST marks the final allowed one.
    assign timeout = (TIMEOUT_CYCLES != 0) && (tcnt == TLAST) && !bus_ready;

    lsu_load_align u_align (
        .rword (bus_rdata),
        .addr  (r_addr[1:0]),
        .func3 (r_func3),
        .rdata (load_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        bus_sel    = 1'b0;
        bus_enable = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = dec_err ? RESP : SETUP;
            end
            SETUP: begin
                bus_sel = 1'b1;
                state_n = ACCESS;
            end
            ACCESS: begin
                bus_sel    = 1'b1;
                bus_enable = 1'b1;
                if (bus_ready || timeout) state_n = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
        bus_write  = bus_sel & r_we;
        bus_addr   = bus_sel ? {r_addr[31:2], 2'b00} : 32'd0;
        bus_wdata  = bus_sel ? r_wdata : 32'd0;
        bus_strb   = bus_sel ? r_strb : 4'd0;
        resp_err   = resp_valid & r_err;
        resp_rdata = resp_valid ? r_rdata : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_func3 <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            tcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_func3 <= req_func3;
                        r_wdata <= lane_wdata(lsu_size_t'(req_func3[1:0]), req_wdata);
                        r_strb  <= req_we ? lane_strb(lsu_size_t'(req_func3[1:0]), req_addr[1:0]) : 4'd0;
                        r_err   <= dec_err;
                        r_rdata <= '0;
                        tcnt    <= '0;
                    end
                end
                ACCESS: begin
                    if (bus_ready)
                        r_rdata <= r_we ? 32'd0 : load_rdata;
                    else if (timeout)
                        r_err <= 1'b1;
                    else if (TIMEOUT_CYCLES != 0)
                        tcnt <= tcnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
